// File: rtl/jk_ff_checker.sv
// Self-checking monitor for a JK flip-flop. It runs an independent golden model of Q
// from the shared j/k stimulus and flags disagreements with the observed q / q_bar.
module jk_ff_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             mismatch,
    output logic             comp_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [1:0]       first_jk
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             model_q;
    logic             mismatch_q;
    logic             comp_err_q;
    logic             sticky_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] chk_cnt_q;
    logic [1:0]       first_jk_q;
    logic             first_seen_q;
    logic [1:0]       jk_q;

    logic             mm_d;
    logic             ce_d;
    logic             nxt_obs_d;
    logic             nxt_model_d;

    function automatic logic jk_next(input logic x, input logic jj, input logic kk);
        logic r;
        case ({jj, kk})
            2'b00:   r = x;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~x;
        endcase
        return r;
    endfunction

    always_comb begin
        mm_d        = (q != model_q);
        ce_d        = (q_bar == q);
        nxt_obs_d   = jk_next(q, j, k);
        nxt_model_d = jk_next(model_q, j, k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            model_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            comp_err_q   <= 1'b0;
            sticky_q     <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
            first_jk_q   <= 2'b00;
            first_seen_q <= 1'b0;
            jk_q         <= 2'b00;
        end else begin
            mismatch_q <= 1'b0;
            comp_err_q <= 1'b0;
            jk_q       <= {j, k};
            case (state_q)
                S_IDLE: begin
                    model_q <= q;
                    if (en) state_q <= S_SYNC;
                end
                S_SYNC: begin
                    model_q <= nxt_obs_d;
                    state_q <= en ? S_CHECK : S_IDLE;
                end
                S_CHECK: begin
                    mismatch_q <= mm_d;
                    comp_err_q <= ce_d;
                    if (chk_cnt_q != CNT_MAX) chk_cnt_q <= chk_cnt_q + CNT_ONE;
                    if (mm_d || ce_d) begin
                        sticky_q <= 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
                    end
                    // jk_q holds the stimulus of the transition whose result is compared now
                    if (mm_d && !first_seen_q) begin
                        first_jk_q   <= jk_q;
                        first_seen_q <= 1'b1;
                    end
                    model_q <= mm_d ? nxt_obs_d : nxt_model_d;
                    state_q <= en ? S_CHECK : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign exp_q       = model_q;
    assign mismatch    = mismatch_q;
    assign comp_err    = comp_err_q;
    assign err_sticky  = sticky_q;
    assign err_count   = err_cnt_q;
    assign check_count = chk_cnt_q;
    assign first_jk    = first_jk_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: a behavioural JK flip-flop with injectable faults drives the
// checker; table vectors plus directed sequences compare against hand-computed values.
module tb_jk_ff_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic j = 1'b0;
    logic k = 1'b0;
    logic [1:0] fmode = 2'd0;   // 0 normal, 1 q stuck-at-0, 2 q stuck-at-1
    logic qbb = 1'b0;           // drive q_bar equal to q
    logic ff_q;
    logic q, q_bar;

    logic       exp_q, mismatch, comp_err, err_sticky;
    logic [7:0] err_count, check_count;
    logic [1:0] first_jk;
    logic       exp_q2, mismatch2, comp_err2, err_sticky2;
    logic [1:0] err_count2, check_count2;
    logic [1:0] first_jk2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) ff_q <= 1'b0;
        else case ({j, k})
            2'b00:   ff_q <= ff_q;
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            default: ff_q <= ~ff_q;
        endcase
    end

    assign q     = (fmode == 2'd1) ? 1'b0 : (fmode == 2'd2) ? 1'b1 : ff_q;
    assign q_bar = qbb ? q : ~q;

    jk_ff_checker #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .exp_q(exp_q), .mismatch(mismatch), .comp_err(comp_err), .err_sticky(err_sticky),
        .err_count(err_count), .check_count(check_count), .first_jk(first_jk)
    );

    jk_ff_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .exp_q(exp_q2), .mismatch(mismatch2), .comp_err(comp_err2), .err_sticky(err_sticky2),
        .err_count(err_count2), .check_count(check_count2), .first_jk(first_jk2)
    );

    typedef struct {
        logic       rst, en, j, k;
        logic [1:0] fm;
        logic       qbb;
        logic       e_expq, e_mm, e_ce;
        logic [7:0] e_cc, e_ec;
        logic       e_st;
        logic [1:0] e_fjk;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst en j  k  fm qbb  expq mm ce  cc ec st fjk
        tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[1]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[2]  = '{0, 1, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[3]  = '{0, 1, 1, 0, 0, 0,   1, 0, 0,  1, 0, 0, 2'b00};
        tbl[4]  = '{0, 1, 1, 1, 0, 0,   0, 0, 0,  2, 0, 0, 2'b00};
        tbl[5]  = '{0, 1, 1, 1, 0, 0,   1, 0, 0,  3, 0, 0, 2'b00};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0,  4, 0, 0, 2'b00};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0,  4, 0, 0, 2'b00};
        tbl[8]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[9]  = '{0, 1, 1, 0, 1, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[10] = '{0, 1, 1, 0, 1, 0,   1, 0, 0,  0, 0, 0, 2'b00};
        tbl[11] = '{0, 1, 1, 0, 1, 0,   1, 1, 0,  1, 1, 1, 2'b10};
        tbl[12] = '{0, 1, 1, 0, 1, 0,   1, 1, 0,  2, 2, 1, 2'b10};
        tbl[13] = '{0, 0, 1, 0, 1, 0,   1, 1, 0,  3, 3, 1, 2'b10};
        tbl[14] = '{0, 0, 0, 0, 1, 0,   0, 0, 0,  3, 3, 1, 2'b10};
        tbl[15] = '{1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[16] = '{0, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[17] = '{0, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 2'b00};
        tbl[18] = '{0, 1, 1, 0, 0, 1,   1, 0, 1,  1, 1, 1, 2'b00};
        tbl[19] = '{0, 1, 0, 1, 0, 0,   0, 0, 0,  2, 1, 1, 2'b00};
        tbl[20] = '{0, 1, 0, 0, 2, 0,   1, 1, 0,  3, 2, 1, 2'b01};
        tbl[21] = '{0, 0, 0, 0, 0, 0,   0, 1, 0,  4, 3, 1, 2'b01};

        #1;
        for (int i = 0; i < 22; i++) begin
            reset = tbl[i].rst; en = tbl[i].en; j = tbl[i].j; k = tbl[i].k;
            fmode = tbl[i].fm;  qbb = tbl[i].qbb;
            step();
            chk("exp_q",       i, {7'd0, exp_q},      {7'd0, tbl[i].e_expq});
            chk("mismatch",    i, {7'd0, mismatch},   {7'd0, tbl[i].e_mm});
            chk("comp_err",    i, {7'd0, comp_err},   {7'd0, tbl[i].e_ce});
            chk("check_count", i, check_count,        tbl[i].e_cc);
            chk("err_count",   i, err_count,          tbl[i].e_ec);
            chk("err_sticky",  i, {7'd0, err_sticky}, {7'd0, tbl[i].e_st});
            chk("first_jk",    i, {6'd0, first_jk},   {6'd0, tbl[i].e_fjk});
        end

        // narrow counters saturate at 3 while the stuck fault keeps pulsing
        reset = 1; en = 0; fmode = 0; qbb = 0; j = 0; k = 0;
        step();
        reset = 0; en = 1; j = 1; k = 0; fmode = 1;
        step();
        step();
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("sat_mismatch2",  i, {7'd0, mismatch2},   8'd1);
            chk("sat_err_count2", i, {6'd0, err_count2},  (i < 3) ? 8'(i) : 8'd3);
            chk("sat_check2",     i, {6'd0, check_count2}, (i < 3) ? 8'(i) : 8'd3);
            chk("sat_sticky2",    i, {7'd0, err_sticky2}, 8'd1);
            chk("sat_err_count8", i, err_count,           8'(i));
        end

        // reset mid-CHECK with a mismatch pending
        reset = 1; en = 0; fmode = 0; j = 0; k = 0;
        step();
        reset = 0; en = 1; j = 1; k = 0;
        step();
        step();
        fmode = 1; reset = 1;
        step();
        chk("rst_mismatch",  0, {7'd0, mismatch},   8'd0);
        chk("rst_err_count", 0, err_count,          8'd0);
        chk("rst_check",     0, check_count,        8'd0);
        chk("rst_sticky",    0, {7'd0, err_sticky}, 8'd0);
        chk("rst_exp_q",     0, {7'd0, exp_q},      8'd0);
        chk("rst_first_jk",  0, {6'd0, first_jk},   8'd0);
        reset = 0;
        step();
        chk("rst_idle_check", 1, check_count,      8'd0);
        chk("rst_idle_mm",    1, {7'd0, mismatch}, 8'd0);
        step();
        chk("rst_sync_check", 2, check_count,      8'd0);
        step();
        chk("rst_resume_mm",  3, {7'd0, mismatch}, 8'd1);
        chk("rst_resume_cc",  3, check_count,      8'd1);

        // en toggled during jk=11 must resync without a false mismatch
        reset = 1; en = 0; fmode = 0; j = 0; k = 0;
        step();
        reset = 0; en = 1; j = 1; k = 1;
        step();
        step();
        chk("tog_exp_q", 2, {7'd0, exp_q}, 8'd0);
        step();
        chk("tog_check", 3, check_count, 8'd1);
        en = 0;
        step();
        chk("tog_check", 4, check_count, 8'd2);
        en = 1;
        step();
        chk("tog_check", 5, check_count, 8'd2);
        step();
        chk("tog_check", 6, check_count,      8'd2);
        chk("tog_exp_q", 6, {7'd0, exp_q},    8'd0);
        chk("tog_mm",    6, {7'd0, mismatch}, 8'd0);
        step();
        chk("tog_check", 7, check_count,      8'd3);
        chk("tog_mm",    7, {7'd0, mismatch}, 8'd0);
        step();
        chk("tog_check",  8, check_count,        8'd4);
        chk("tog_mm",     8, {7'd0, mismatch},   8'd0);
        chk("tog_sticky", 8, {7'd0, err_sticky}, 8'd0);
        chk("tog_errs",   8, err_count,          8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_ff_checker.md
# jk_ff_checker

Synthesizable self-checking monitor for the JK flip-flop: the observing end of the JK stimulus interface. It samples the same j/k stimulus that drives the flip-flop, runs an independent golden model of Q, and compares it every cycle against the flip-flop's q and q_bar outputs. It reports per-cycle mismatch pulses, a sticky error flag, saturating error and check counters, and the j/k pair of the first failing transition. It sits beside the flip-flop in benches and on-chip BIST wrappers.

## Interface
- CNT_W, 8, width of err_count and check_count (saturating)
- clk  in  1  rising-edge clock, shared with the flip-flop under check
- reset  in  1  synchronous, active-high; clears all state and outputs
- en  in  1  checking enable; low = idle/resync
- j  in  1  J stimulus, the same net that drives the flip-flop
- k  in  1  K stimulus, the same net that drives the flip-flop
- q  in  1  observed flip-flop Q
- q_bar  in  1  observed flip-flop Q-bar
- exp_q  out  1  golden-model Q for the current cycle
- mismatch  out  1  one-cycle pulse: q != exp_q
- comp_err  out  1  one-cycle pulse: q_bar != ~q
- err_sticky  out  1  set on any error; cleared only by reset
- err_count  out  CNT_W  count of error cycles, saturating at all-ones
- check_count  out  CNT_W  count of compared cycles, saturating at all-ones
- first_jk  out  2  {j,k} that produced the first mismatch; valid while err_sticky=1

## Operation
- Next-state function nxt(x,j,k): 00→x, 01→0, 10→1, 11→~x.
- States:
  - IDLE: entered on reset or when en=0.
  - SYNC: one cycle.
  - CHECK.
- IDLE:
  - No compares.
  - exp_q tracks observed q each cycle.
  - en=1 → SYNC.
- SYNC:
  - exp_q <= nxt(q,j,k), seeding the model from observed Q.
  - No compare.
  - → CHECK if en=1, else → IDLE.
- CHECK, each cycle:
  - Compare q vs exp_q, and q_bar vs ~q.
  - Without a mismatch, exp_q <= nxt(exp_q,j,k), so the model runs independently.
  - On a mismatch, exp_q <= nxt(q,j,k). This resyncs the model so one fault gives one error, not a cascade.
  - en=0 → IDLE; the compare on that cycle is still performed.
- Error accounting:
  - check_count increments on every CHECK cycle.
  - err_count increments once per cycle in which mismatch or comp_err is asserted; both together count as 1.
  - Both counters hold at 2^CNT_W−1.
- first_jk captures the registered {j,k} of the transition under test on the first mismatch since reset. It is not updated afterwards.
- comp_err alone sets err_sticky and increments err_count, but does not touch first_jk or exp_q.

## Timing
- j/k are sampled at edge N. The flip-flop updates q at edge N. The checker compares that q at edge N+1.
- Mismatch latency: mismatch/comp_err are registered and assert in the cycle after edge N+1, high for exactly one cycle per failing compare.
- err_sticky, err_count and first_jk update on the same edge as the mismatch pulse.
- Reset values: exp_q=0, mismatch=0, comp_err=0, err_sticky=0, err_count=0, check_count=0, first_jk=00, state=IDLE.
- reset has priority over en. Asserting reset mid-CHECK aborts the compare in progress, with no pulse and no count.
- While the flip-flop is also in reset (q=0), the checker stays in IDLE and never flags.
- en deasserted and reasserted always passes through SYNC again. There is no compare on the SYNC cycle.
- Counter saturation: at 2^CNT_W−1 further errors still pulse mismatch and keep err_sticky=1, but the count does not wrap.

## Test plan
- Reset, then en=1 with the sequence jk=00,01,10,11,11 against a correct flip-flop → q follows 0,0,1,0,1; mismatch never asserts; check_count=4 (SYNC excluded); err_sticky=0.
- Force q stuck-at-0, en=1, jk=10 held 3 cycles → one mismatch pulse per cycle (resync expects 1 each time); err_count=3; first_jk=10; err_sticky=1.
- Drive q_bar=q for one CHECK cycle with q correct → comp_err pulses once; mismatch=0; err_count=1; first_jk stays 00.
- CNT_W=2, continuous stuck fault for 6 cycles → err_count sticks at 3; mismatch still pulses every cycle.
- Assert reset mid-CHECK with a fault pending → no pulse; all outputs return to reset values the next cycle; state=IDLE.
- Toggle en 1→0→1 during jk=11 → no compare on the SYNC cycle; exp_q reseeds from observed q; no false mismatch.
